// File: rtl/serial_bit_feeder_pkg.sv
// rtl/serial_bit_feeder_pkg.sv - shared types and constants for the serial bit feeder
package serial_bit_feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_W = 8;

  // Pattern the downstream sliding-window detector looks for.
  localparam logic [7:0] TARGET_PATTERN = 8'hE7;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// rtl/serial_bit_feeder_if.sv - word handshake in, serial bit stream out
interface serial_bit_feeder_if
  import serial_bit_feeder_pkg::*;
#(
  parameter int W = DEFAULT_W
) ();

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out;
  logic         out_valid;
  logic         word_done;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out,
    input  out_valid,
    input  word_done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out,
    output out_valid,
    output word_done
  );

endinterface

// File: rtl/serial_bit_feeder_hold.sv
// rtl/serial_bit_feeder_hold.sv - one-entry word register with valid, load and take
module word_hold_reg
  import serial_bit_feeder_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         take,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// rtl/serial_bit_feeder.sv - buffers parallel words and shifts them out one bit per clock
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int   W         = DEFAULT_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  serial_bit_feeder_if.slave  bus,
  output logic                busy
);

  localparam int            CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          ov_q, ov_d;
  logic          wd_q, wd_d;
  logic [W-1:0]  hold_data;
  logic          hold_valid;
  logic          hold_load;
  logic          hold_take;
  logic          accept;

  // The bit currently on `out` always sits at the leading end of sh.
  function automatic logic lead_bit(input logic [W-1:0] w);
    return MSB_FIRST ? w[W-1] : w[0];
  endfunction

  function automatic logic [W-1:0] advance(input logic [W-1:0] w);
    return MSB_FIRST ? {w[W-2:0], 1'b0} : {1'b0, w[W-1:1]};
  endfunction

  assign accept = bus.in_valid && !hold_valid;

  word_hold_reg #(.W(W)) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (hold_load),
    .take  (hold_take),
    .din   (bus.in_data),
    .dout  (hold_data),
    .valid (hold_valid)
  );

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    hold_load = 1'b0;
    hold_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sh_d    = bus.in_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          if (hold_valid) begin
            hold_take = 1'b1;
            sh_d      = hold_data;
            cnt_d     = '0;
          end else if (accept) begin
            sh_d  = bus.in_data;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sh_d      = advance(sh_q);
          cnt_d     = cnt_q + CW'(1);
          hold_load = accept;
        end
      end
      default: state_d = IDLE;
    endcase
    out_d = (state_d == SHIFT) ? lead_bit(sh_d) : IDLE_BIT;
    ov_d  = (state_d == SHIFT);
    wd_d  = (state_d == SHIFT) && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      out_q <= IDLE_BIT;
      ov_q  <= 1'b0;
      wd_q  <= 1'b0;
    end else if (flush) begin
      sh_q  <= '0;
      cnt_q <= '0;
      out_q <= IDLE_BIT;
      ov_q  <= 1'b0;
      wd_q  <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      ov_q  <= ov_d;
      wd_q  <= wd_d;
    end
  end

  assign bus.in_ready  = !hold_valid;
  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.word_done = wd_q;
  assign busy          = (state_q == SHIFT) || hold_valid;

endmodule
